uart_mem_loader: RTL
====================

# uart_mem_loader

UART-driven data-memory writer for the RISC-V pipeline CPU. It receives framed byte packets on a serial line, assembles 32-bit words, and issues single-cycle write strobes into the CPU data memory, so a host can seed counter or test values that the display path later reads from memory. It sits beside the CPU in the top-level wrapper and drives the data memory's external write port.

## Interface
Parameters:
- CLKS_PER_BIT, 434 — clock cycles per UART bit (50 MHz / 115200 baud).
- ADDR_WIDTH, 7 — word-address width (128-word data memory).
- GAP_BITS, 16 — inter-byte timeout, in bit-times, allowed mid-frame.

Ports:
- clk  in  1  — single clock; all logic is on the rising edge.
- reset  in  1  — asynchronous, active-low reset.
- enable  in  1  — parser enable. When low, the parser is held in IDLE and received bytes are dropped.
- uart_rx  in  1  — serial input, idle high, 8N1, LSB first.
- mem_we  out  1  — one-cycle write strobe.
- mem_addr  out  ADDR_WIDTH  — word address, valid while mem_we is high.
- mem_wdata  out  32  — write data, valid while mem_we is high.
- frame_ok  out  1  — one-cycle pulse when a frame is accepted.
- frame_err  out  1  — one-cycle pulse when a frame is rejected.
- busy  out  1  — high whenever the parser is not in IDLE.

## Operation
- uart_rx passes through a 2-flop synchroniser; the synchroniser resets to 1.
- The byte receiver FSM has states R_IDLE, R_START, R_DATA, R_STOP:
  - A falling edge in R_IDLE enters R_START.
  - R_START samples at CLKS_PER_BIT/2. If the line is high, the edge is treated as a glitch and the FSM returns to R_IDLE.
  - R_DATA samples the 8 data bits, one every CLKS_PER_BIT cycles.
  - R_STOP samples the stop bit. A 1 yields a one-cycle byte_valid; a 0 is a framing error (byte dropped, parser sees a byte error).
- Frame format: 0xA5, ADDR, D0, D1, D2, D3, then CSUM (CSUM only when configured). Data is little-endian, so mem_wdata = {D3,D2,D1,D0}.
- The parser FSM has states P_IDLE, P_ADDR, P_D0, P_D1, P_D2, P_D3, P_CSUM:
  - P_IDLE ignores every byte except 0xA5, and does not flag the ignored bytes.
  - In P_ADDR, address bits above ADDR_WIDTH must be zero. Otherwise frame_err fires and the parser returns to P_IDLE.
  - The frame completes on the last byte: mem_we and frame_ok pulse, and the parser returns to P_IDLE.
- Any of the following mid-frame (parser not in P_IDLE) sends the parser to P_IDLE and pulses frame_err:
  - a byte framing error;
  - no byte for GAP_BITS×CLKS_PER_BIT cycles since the last byte_valid.
- If enable goes low mid-frame, the parser aborts to P_IDLE silently, with no frame_err.
- A 0xA5 received mid-frame is treated as data, not as a resync.

## Timing
- Reset values:
  - mem_we, frame_ok, frame_err, busy = 0.
  - mem_addr = 0, mem_wdata = 0.
  - Both FSMs in their idle state.
- byte_valid rises 2 (synchroniser) + 9.5×CLKS_PER_BIT cycles after the start-bit falling edge.
- mem_we and frame_ok are registered. They assert exactly 1 cycle after byte_valid of the final byte, for 1 cycle.
- mem_addr and mem_wdata hold their value until the next write.
- frame_err is registered and asserts 1 cycle after the detecting event.
- busy rises the cycle after 0xA5 is accepted and falls in the same cycle that mem_we or frame_err is high.
- Reset asserted mid-byte or mid-frame clears everything immediately; no partial write ever occurs.

## Configuration
- LOADER_CHECKSUM_EN:
  - Defined: the frame includes CSUM = ADDR ^ D0 ^ D1 ^ D2 ^ D3. A mismatch gives frame_err and no write.
  - Undefined: P_CSUM is removed and the frame completes on D3.

## Structure
- Package loader_pkg holds:
  - the SYNC_BYTE constant 0xA5;
  - the receiver and parser state enums;
  - the default CLKS_PER_BIT.
- Sub-module uart_rx_byte contains the synchroniser and the byte receiver FSM. Its outputs are byte_data[7:0], byte_valid and byte_err.
- The top level holds the parser, the timeout counter, the checksum accumulator and the output registers.

## Test plan
- Frame A5 03 78 56 34 12 (plus checksum 0x03^0x78^0x56^0x34^0x12 = 0x0B when LOADER_CHECKSUM_EN is defined) → one mem_we pulse with mem_addr=3, mem_wdata=0x12345678, and frame_ok.
- Same frame with a bad CSUM of 0x00, checksum enabled → frame_err, mem_we stays 0.
- Leading garbage 00 FF, then a valid frame to address 0 with data 0x0000000F → exactly one write; no frame_err from the garbage.
- ADDR=0x80 with ADDR_WIDTH=7 → frame_err 1 cycle after the ADDR byte; subsequent data bytes are ignored until the next 0xA5.
- Stop bit forced to 0 on D1 → frame_err, no write; a following valid frame writes normally.
- Send A5 02 then idle for more than 16 bit-times → frame_err and busy=0. Reset pulled low mid-D2 of a new frame → all outputs 0, no write.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state enums for the UART memory loader (LOADER_CHECKSUM_EN adds P_CSUM)
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE            = 8'hA5;
    localparam int         DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_ADDR,
        P_D0,
        P_D1,
        P_D2,
        P_D3
`ifdef LOADER_CHECKSUM_EN
        , P_CSUM
`endif
    } p_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 2-flop synchroniser and 8N1 byte receiver with stop-bit framing check
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q, prev_d;
    rx_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    assign byte_data  = data_q;
    assign byte_valid = valid_q;
    assign byte_err   = err_q;

    // Bit timing: detect the start edge, centre on each bit, shift LSB first, check the stop bit.
    always_comb begin
        sync1_d = uart_rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                // Edge rather than level, so a line held low after a framing error does not retrigger.
                if (prev_q && !sync2_q) begin
                    state_d = R_START;
                end
            end
            R_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = sync2_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = R_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = R_IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Receiver state; the synchroniser resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - UART frame parser writing 32-bit words to data memory (optional checksum: LOADER_CHECKSUM_EN)
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_WIDTH   = 7,
    parameter int GAP_BITS     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  uart_rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
`ifdef LOADER_CHECKSUM_EN
    localparam int DATA_W = 32;
`else
    localparam int DATA_W = 24;
`endif

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_err;

    p_state_t              p_state_q, p_state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  mem_we_q, mem_we_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  frame_err_q, frame_err_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign busy      = (p_state_q != P_IDLE);

    // Frame parser: abort conditions first, then walk the byte sequence and commit on the last byte.
    always_comb begin
        p_state_d   = p_state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mem_we_d    = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        // The gap timer only runs mid-frame and restarts on every received byte.
        gap_d = (p_state_q == P_IDLE || byte_valid) ? '0 : gap_q + 1'b1;

        if (!enable) begin
            p_state_d = P_IDLE;
        end else if (p_state_q != P_IDLE && byte_err) begin
            p_state_d   = P_IDLE;
            frame_err_d = 1'b1;
        end else if (p_state_q != P_IDLE && !byte_valid && gap_q == GAP_LAST) begin
            p_state_d   = P_IDLE;
            frame_err_d = 1'b1;
        end else if (byte_valid) begin
            case (p_state_q)
                P_IDLE: begin
                    if (byte_data == SYNC_BYTE) begin
                        p_state_d = P_ADDR;
                    end
                end
                P_ADDR: begin
                    if ((byte_data >> ADDR_WIDTH) != 8'd0) begin
                        p_state_d   = P_IDLE;
                        frame_err_d = 1'b1;
                    end else begin
                        addr_d    = ADDR_WIDTH'(byte_data);
`ifdef LOADER_CHECKSUM_EN
                        csum_d    = byte_data;
`endif
                        p_state_d = P_D0;
                    end
                end
                P_D0: begin
                    data_d[7:0] = byte_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ byte_data;
`endif
                    p_state_d   = P_D1;
                end
                P_D1: begin
                    data_d[15:8] = byte_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d       = csum_q ^ byte_data;
`endif
                    p_state_d    = P_D2;
                end
                P_D2: begin
                    data_d[23:16] = byte_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d        = csum_q ^ byte_data;
`endif
                    p_state_d     = P_D3;
                end
`ifdef LOADER_CHECKSUM_EN
                P_D3: begin
                    data_d[31:24] = byte_data;
                    csum_d        = csum_q ^ byte_data;
                    p_state_d     = P_CSUM;
                end
                P_CSUM: begin
                    p_state_d = P_IDLE;
                    if (csum_q == byte_data) begin
                        mem_we_d    = 1'b1;
                        frame_ok_d  = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = data_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
`else
                P_D3: begin
                    p_state_d   = P_IDLE;
                    mem_we_d    = 1'b1;
                    frame_ok_d  = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = {byte_data, data_q};
                end
`endif
                default: p_state_d = P_IDLE;
            endcase
        end
    end

    // Parser state and registered memory-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_state_q   <= P_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            gap_q       <= '0;
            mem_we_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            p_state_q   <= p_state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            gap_q       <= gap_d;
            mem_we_q    <= mem_we_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule
